// File: rtl/xlu_sequencer_pkg.sv
// Shared definitions for the E-stage HI/LO unit: op codes (same encoding the
// E-stage controller emits), FSM state encoding and op classification helpers.
package xlu_sequencer_pkg;

  localparam logic [3:0] XLU_MULT  = 4'b0000;
  localparam logic [3:0] XLU_MULTU = 4'b0001;
  localparam logic [3:0] XLU_DIV   = 4'b0010;
  localparam logic [3:0] XLU_DIVU  = 4'b0011;
  localparam logic [3:0] XLU_MTHI  = 4'b0100;
  localparam logic [3:0] XLU_MTLO  = 4'b0101;
  localparam logic [3:0] XLU_MFHI  = 4'b0110;
  localparam logic [3:0] XLU_MFLO  = 4'b0111;
  localparam logic [3:0] XLU_NONE  = 4'b1000;
  localparam logic [3:0] XLU_MADD  = 4'b1001;
  localparam logic [3:0] XLU_MADDU = 4'b1010;
  localparam logic [3:0] XLU_MSUB  = 4'b1011;
  localparam logic [3:0] XLU_MSUBU = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } xlu_state_e;

  function automatic logic xlu_is_div(input logic [3:0] op);
    return (op == XLU_DIV) || (op == XLU_DIVU);
  endfunction

  // Ops that occupy the unit for multiple cycles and raise busy.
  function automatic logic xlu_is_muldiv(input logic [3:0] op);
    return (op == XLU_MULT) || (op == XLU_MULTU) || xlu_is_div(op) ||
           (op == XLU_MADD) || (op == XLU_MADDU) ||
           (op == XLU_MSUB) || (op == XLU_MSUBU);
  endfunction

endpackage

// File: rtl/xlu_compute.sv
// Combinational HI/LO result generator. Isolated from the sequencer so it can
// later be swapped for an iterative divider without touching the FSM.
module xlu_compute
  import xlu_sequencer_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic [31:0] new_hi_o,
  output logic [31:0] new_lo_o,
  output logic        wr_en_o
);

  logic signed [63:0] a_s64, b_s64;
  logic signed [31:0] a_s32, b_s32;
  logic        [63:0] prod_s, prod_u, acc, res;
  logic        [31:0] quot_s, rem_s, quot_u, rem_u;
  logic               b_zero;

  assign a_s64  = {{32{a_i[31]}}, a_i};
  assign b_s64  = {{32{b_i[31]}}, b_i};
  assign a_s32  = a_i;
  assign b_s32  = b_i;
  assign prod_s = a_s64 * b_s64;
  assign prod_u = {32'b0, a_i} * {32'b0, b_i};
  assign acc    = {hi_i, lo_i};
  assign b_zero = (b_i == 32'b0);

  // Quotient/remainder are only consumed when b is non-zero.
  assign quot_s = a_s32 / b_s32;
  assign rem_s  = a_s32 % b_s32;
  assign quot_u = a_i / b_i;
  assign rem_u  = a_i % b_i;

  always_comb begin
    res     = acc;
    wr_en_o = 1'b0;
    case (op_i)
      XLU_MULT:  begin res = prod_s;       wr_en_o = 1'b1; end
      XLU_MULTU: begin res = prod_u;       wr_en_o = 1'b1; end
      XLU_DIV:   begin res = {rem_s, quot_s}; wr_en_o = !b_zero; end
      XLU_DIVU:  begin res = {rem_u, quot_u}; wr_en_o = !b_zero; end
      XLU_MADD:  begin res = acc + prod_s; wr_en_o = 1'b1; end
      XLU_MADDU: begin res = acc + prod_u; wr_en_o = 1'b1; end
      XLU_MSUB:  begin res = acc - prod_s; wr_en_o = 1'b1; end
      XLU_MSUBU: begin res = acc - prod_u; wr_en_o = 1'b1; end
      default:   ;
    endcase
  end

  assign new_hi_o = res[63:32];
  assign new_lo_o = res[31:0];

endmodule

// File: rtl/xlu_sequencer.sv
// Multi-cycle scheduler for the E-stage HI/LO unit. Owns HI/LO and drives the
// start/busy pair the hazard unit uses to stall dependent instructions in D.
module xlu_sequencer
  import xlu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  xlu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  xlu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      c_hi, c_lo;
  logic             c_wr;

  assign start = op_valid && (state_q == ST_IDLE) && xlu_is_muldiv(xlu_op);
  assign busy  = (state_q == ST_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;

  xlu_compute u_compute (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .new_hi_o (c_hi),
    .new_lo_o (c_lo),
    .wr_en_o  (c_wr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = xlu_op;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = xlu_is_div(xlu_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (op_valid && (xlu_op == XLU_MTHI)) begin
          hi_d = rs_val;
        end else if (op_valid && (xlu_op == XLU_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_RUN: begin
        // Inputs are ignored here; the hazard unit keeps D stalled while busy.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (c_wr) begin
            hi_d = c_hi;
            lo_d = c_lo;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_xlu_sequencer.sv
// Directed bench for xlu_sequencer: issue-time result model with a busy
// countdown, checked every cycle, plus hand-computed literal expectations.
module tb_xlu_sequencer;
  import xlu_sequencer_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [3:0]  xlu_op = XLU_NONE;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        start, busy;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nerr = 0;
  int hazard_cnt = 0;

  // Model state: architectural HI/LO, cycles of busy left, pending result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;

  xlu_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .xlu_op   (xlu_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .start    (start),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic md_op(input logic [3:0] op);
    return (op <= 4'd3) || (op >= 4'd9 && op <= 4'd12);
  endfunction

  // Result is fixed at issue: HI/LO cannot change while the unit is busy.
  task automatic model_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    longint             ps;
    logic [63:0]        pu, acc, res;
    sa  = a;
    sb  = b;
    ps  = longint'(sa) * longint'(sb);
    pu  = {32'b0, a} * {32'b0, b};
    acc = {m_hi, m_lo};
    res = acc;
    case (op)
      4'd0:  res = ps;
      4'd1:  res = pu;
      4'd2:  if (b != 0) res = {32'(sa % sb), 32'(sa / sb)};
      4'd3:  if (b != 0) res = {a % b, a / b};
      4'd4:  m_hi = a;
      4'd5:  m_lo = a;
      4'd9:  res = acc + ps;
      4'd10: res = acc + pu;
      4'd11: res = acc - ps;
      4'd12: res = acc - pu;
      default: ;
    endcase
    if (md_op(op)) begin
      p_hi   = res[63:32];
      p_lo   = res[31:0];
      m_left = (op == 4'd2 || op == 4'd3) ? DIV_N : MULT_N;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (op_valid) begin
      model_issue(xlu_op, rs_val, rt_val);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("start", {31'b0, start}, {31'b0, op_valid && (m_left == 0) && md_op(xlu_op)});
    chk("busy",  {31'b0, busy},  {31'b0, m_left > 0});
    chk("hi",    hi, m_hi);
    chk("lo",    lo, m_lo);
  end

  // Protocol monitor: a real op while busy is a hazard-unit violation.
  always @(negedge clk) begin
    if (!reset && op_valid && busy && (md_op(xlu_op) || xlu_op == XLU_MTHI || xlu_op == XLU_MTLO)) begin
      hazard_cnt++;
      $display("note: op %h presented while busy at %0t", xlu_op, $time);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; xlu_op = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    op_valid = 1'b0; xlu_op = XLU_NONE;
  endtask

  // Counts busy cycles until the first idle negedge (bounded).
  task automatic run_busy(input string name, input int exp_n);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk(name, n, exp_n);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);

    // 1: signed mult
    issue(XLU_MULT, 32'hFFFF_FFFE, 32'd3);
    run_busy("mult_len", MULT_N);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // 2: divides, issued back-to-back in the first idle cycle
    issue(XLU_DIVU, 32'd100, 32'd7);
    run_busy("divu_len", DIV_N);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    issue(XLU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy("div_len", DIV_N);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    issue(XLU_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_busy("multu_len", MULT_N);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // 3: accumulate family
    issue(XLU_MTHI, 32'h1234_5678, 32'd0);
    issue(XLU_MTLO, 32'd1, 32'd0);
    chk("mt_hi", hi, 32'h1234_5678);
    chk("mt_lo", lo, 32'd1);
    issue(XLU_MADD, 32'h1_0000, 32'h1_0000);
    run_busy("madd_len", MULT_N);
    chk("madd_hi", hi, 32'h1234_5679);
    chk("madd_lo", lo, 32'd1);
    issue(XLU_MSUBU, 32'h1_0000, 32'h1_0000);
    run_busy("msubu_len", MULT_N);
    chk("msubu_hi", hi, 32'h1234_5678);
    chk("msubu_lo", lo, 32'd1);
    issue(XLU_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy("maddu_len", MULT_N);
    chk("maddu_hi", hi, 32'h1234_5676);
    chk("maddu_lo", lo, 32'd2);
    issue(XLU_MSUB, 32'hFFFF_FFFF, 32'd1);
    run_busy("msub_len", MULT_N);
    chk("msub_hi", hi, 32'h1234_5676);
    chk("msub_lo", lo, 32'd3);

    // 4: divide by zero keeps HI/LO
    issue(XLU_MTLO, 32'hAA, 32'd0);
    issue(XLU_DIV, 32'd5, 32'd0);
    run_busy("div0_len", DIV_N);
    chk("div0_lo", lo, 32'hAA);
    chk("div0_hi", hi, 32'h1234_5676);

    // 6a: op_valid=0 and undefined codes do nothing
    op_valid = 1'b0; xlu_op = XLU_MULT; rs_val = 32'd9; rt_val = 32'd9;
    repeat (3) @(negedge clk);
    xlu_op = XLU_MTHI;
    repeat (2) @(negedge clk);
    issue(4'hD, 32'h5555, 32'h5555);
    issue(XLU_MFHI, 32'h5555, 32'h5555);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_hi", hi, 32'h1234_5676);
    chk("idle_lo", lo, 32'hAA);

    // 6b: a second mult while busy is ignored
    issue(XLU_MULT, 32'd7, 32'd6);
    issue(XLU_MULT, 32'd100, 32'd100);
    run_busy("hz_len", MULT_N - 1);
    chk("hz_hi", hi, 32'd0);
    chk("hz_lo", lo, 32'd42);

    // 5: async reset in cycle 3 of a mult aborts it
    issue(XLU_MULT, 32'd3, 32'd3);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_hi", hi, 32'd0);
    chk("ar_lo", lo, 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);

    chk("hazard_seen", hazard_cnt, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
